zap_wb_ram: RTL

On-chip Wishbone B3 RAM slave that sits directly downstream of the ZAP processor's external Wishbone port. It services the single merged master (code and data traffic) with classic single-word cycles and linear incrementing bursts (cache line fills and write-backs) out of a byte-writable synchronous word array. Read latency and initial wait states are fixed and cycle-exact.

---
 rtl/zap_wb_ram_if.sv | 16 +
 rtl/zap_wb_ram.sv | 117 +++++++++++
 2 files changed

// File: rtl/zap_wb_ram_if.sv
// Wishbone B3 bus bundle between the ZAP external port and the on-chip RAM.
interface zap_wb_ram_if;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        we;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic [31:0] dat_r;

  modport master (output cyc, stb, adr, we, dat_w, sel, cti, bte, input ack, dat_r);
  modport slave  (input cyc, stb, adr, we, dat_w, sel, cti, bte, output ack, dat_r);
endinterface

// File: rtl/zap_wb_ram.sv
// Byte-writable synchronous word RAM behind a Wishbone B3 slave port.
// Serves classic single-word cycles and linear incrementing bursts with a
// fixed number of wait states before the first ack of each transaction.
module zap_wb_ram #(
  parameter int unsigned DEPTH       = 32'd16384,
  parameter int unsigned WAIT_STATES = 32'd0
) (
  input logic         i_clk,
  input logic         i_reset,
  zap_wb_ram_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CACK  = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, rd_addr, req_idx;
  logic [3:0]    cnt_q;
  logic          we_q, burst_q;
  logic [31:0]   ram_q, hold_q;
  logic          req, beat_ack, ack, wr_en;

  // Address bits outside the word index and the burst type carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb.bte, wb.adr[1:0], wb.adr[31:AW+2]};

  assign req      = wb.cyc & wb.stb;
  assign req_idx  = wb.adr[AW+1:2];
  // Burst beats are acked in the same cycle the master strobes so a stall
  // (stb low) never produces a stale ack; the state itself is registered.
  assign beat_ack = (state_q == S_BURST) & wb.cyc & wb.stb;
  assign ack      = (state_q == S_CACK) | beat_ack;
  // A reset edge must not commit the write of the beat it aborts.
  assign wr_en    = we_q & ack & ~i_reset;

  assign wb.ack   = ack;
  // Read data only changes while acked; otherwise the last value is replayed.
  assign wb.dat_r = ack ? ram_q : hold_q;

  // RAM read address: new request index in IDLE, prefetch of the next word
  // on an acked burst beat, current word otherwise.
  always_comb begin
    rd_addr = addr_q;
    if (state_q == S_IDLE)
      rd_addr = req_idx;
    else if (beat_ack)
      rd_addr = addr_q + AW'(1);
  end

  // Transaction sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (req) begin
          if (WS != 4'd0)                 state_d = S_WAIT;
          else if (wb.cti == CTI_INCR)    state_d = S_BURST;
          else                            state_d = S_CACK;
        end
      S_WAIT:
        if (!wb.cyc)                      state_d = S_IDLE;
        else if (cnt_q == 4'd1)           state_d = burst_q ? S_BURST : S_CACK;
      S_CACK:                             state_d = S_IDLE;
      S_BURST:
        if (!wb.cyc)                      state_d = S_IDLE;
        else if (beat_ack && wb.cti == CTI_EOB) state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Control registers: state, captured request attributes, wait counter, address.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= wb.dat_r;
      if (state_q == S_IDLE && req) begin
        addr_q  <= req_idx;
        we_q    <= wb.we;
        burst_q <= (wb.cti == CTI_INCR);
        cnt_q   <= WS;
      end else if (state_q == S_WAIT) begin
        cnt_q   <= cnt_q - 4'd1;
      end else if (beat_ack) begin
        addr_q  <= addr_q + AW'(1);
      end
    end
  end

  // One byte-wide RAM per lane so sel maps straight onto lane write enables.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Lane write at the acked word, synchronous read of the selected word.
    always_ff @(posedge i_clk) begin
      if (wr_en && wb.sel[g])
        mem[addr_q] <= wb.dat_w[8*g +: 8];
      rd_q <= mem[rd_addr];
    end

    assign ram_q[8*g +: 8] = rd_q;
  end
endmodule
